// File: rtl/uart_reg_mstr_pkg.sv
// Shared types and constants for the UART reg-bus initiator.
// Optional timeout abort is built in with REG_MSTR_TIMEOUT_EN.
package uart_reg_mstr_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 8;

  localparam logic [REG_DW-1:0] RSP_ERR_DATA = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

endpackage

// File: rtl/uart_reg_master.sv
// Reg-bus initiator: one valid/ready command in, one reg-bus transaction out, one response back.
// Define REG_MSTR_TIMEOUT_EN to abort a REQ that sees no reg_ack within TO_CYC cycles.
module uart_reg_master
  import uart_reg_mstr_pkg::*;
#(
  parameter int AW     = REG_AW,
  parameter int DW     = REG_DW,
  parameter int TO_CYC = 255
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic          cmd_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_be,
  input  logic [DW-1:0] reg_rdata,
  input  logic          reg_ack
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   req_ack;
  logic   to_hit;

  assign accept  = cmd_valid & cmd_ready;
  assign req_ack = (state == REQ) & reg_ack;

`ifdef REG_MSTR_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] to_cnt;

  // an ack in the expiry cycle still wins
  assign to_hit = (state == REQ) & ~reg_ack
                & (to_cnt == CW'(TO_CYC));

  // cycles spent waiting in REQ
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if (state == REQ)
      to_cnt <= to_cnt + CW'(1);
  end

  // error flag follows how REQ ended
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      rsp_err <= 1'b0;
    else if (req_ack)
      rsp_err <= 1'b0;
    else if (to_hit)
      rsp_err <= 1'b1;
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // state register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nxt = REQ;
      REQ:  if (reg_ack || to_hit) state_nxt = RSP;
      RSP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): cmd_ready = 1'b1;
      (state == RSP):  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // reg-bus drive and response capture
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        reg_cs    <= 1'b1;
        reg_wr    <= cmd_wr;
        reg_addr  <= cmd_addr;
        reg_wdata <= cmd_wdata;
        reg_be    <= cmd_be;
      end
      if (req_ack) begin
        reg_cs    <= 1'b0;
        reg_wr    <= 1'b0;
        rsp_rdata <= reg_wr ? '0 : reg_rdata;
      end else if (to_hit) begin
        reg_cs    <= 1'b0;
        reg_wr    <= 1'b0;
        rsp_rdata <= '1;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master: vector table, random traffic vs a memory model, corner sequences.
// Timeout sequence runs only when REG_MSTR_TIMEOUT_EN is defined (TO_CYC=8).
module tb_uart_reg_master;

  localparam int TO = 8;

  logic       mclk = 0;
  logic       reset_n = 0;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic       cmd_wr = 0;
  logic [3:0] cmd_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic       cmd_be = 0;
  logic       rsp_valid;
  logic       rsp_ready = 0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       reg_cs;
  logic       reg_wr;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_be;
  logic [7:0] reg_rdata;
  logic       reg_ack;

  int total = 0;
  int bad = 0;

  always #5 mclk = ~mclk;

  uart_reg_master #(.AW(4), .DW(8), .TO_CYC(TO)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(int i);
    logic [7:0] v;
    v = 8'(i * 19 + 7);
    if (i == 6) v = 8'h5C;
    return v;
  endfunction

  // responder: registered single-cycle ack, memory behind it
  logic       noack = 0;
  logic       spur = 0;
  logic [7:0] spur_data = 8'hEE;
  logic       ack_r;
  logic [7:0] rd_r;
  logic [7:0] mem [16];
  int         ack_cnt;

  assign reg_ack   = ack_r | spur;
  assign reg_rdata = spur ? spur_data : rd_r;

  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r   <= 0;
      rd_r    <= 0;
      ack_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      ack_r <= reg_cs && !ack_r && !noack;
      if (reg_cs && !ack_r && !noack)
        rd_r <= reg_wr ? 8'h00 : mem[reg_addr];
      if (reg_cs && ack_r) begin
        ack_cnt <= ack_cnt + 1;
        if (reg_wr && reg_be) mem[reg_addr] <= reg_wdata;
      end
    end
  end

  // bus monitor: fields during ack, cs pulse and gap tracking
  logic       mon_en = 0;
  logic       exp_wr;
  logic [3:0] exp_a;
  logic [7:0] exp_d;
  logic       exp_be;
  logic       cs_prev = 0;
  int         pulses = 0;
  int         low_run = 0;
  int         gap_last = 0;

  always @(negedge mclk) begin
    if (mon_en && reg_cs && ack_r) begin
      chk("bus_wr", reg_wr, exp_wr);
      chk("bus_addr", reg_addr, exp_a);
      chk("bus_be", reg_be, exp_be);
      if (exp_wr) chk("bus_wdata", reg_wdata, exp_d);
    end
    if (reg_cs && !cs_prev) begin
      pulses++;
      gap_last = low_run;
    end
    if (reg_cs) low_run = 0;
    else low_run++;
    cs_prev = reg_cs;
  end

  task automatic do_txn(input logic wr, input logic [3:0] a,
                        input logic [7:0] d, input logic be,
                        input int hold, input logic sp,
                        output logic [7:0] rd, output logic er,
                        output int lat, output int acks);
    int n;
    int a0;
    logic [7:0] r0;
    logic e0;
    exp_wr = wr; exp_a = a; exp_d = d; exp_be = be;
    @(negedge mclk);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a;
    cmd_wdata = d; cmd_be = be;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge mclk); n++;
    end
    a0 = ack_cnt;
    rd = 0; er = 0; lat = 0; acks = 0;
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(negedge mclk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge mclk); lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    r0 = rsp_rdata; e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_rdata", rsp_rdata, r0);
      chk("hold_err", rsp_err, e0);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_cs", reg_cs, 0);
      spur = sp && (i == 0);
      @(negedge mclk);
    end
    spur = 0;
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1;
    @(negedge mclk);
    rsp_ready = 0;
    acks = ack_cnt - a0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    logic       be;
    int         hold;
    logic       sp;
    logic [7:0] exp_rd;
  } vec_t;

  logic [7:0] ref_mem [16];

  initial begin
    vec_t vt [8];
    logic [7:0] rd;
    logic er;
    int lat, acks, n, p0, a0;

    vt[0] = '{1, 4'h2, 8'h1A, 1, 0, 0, 8'h00};
    vt[1] = '{0, 4'h6, 8'h00, 1, 0, 0, 8'h5C};
    vt[2] = '{0, 4'h6, 8'h00, 1, 5, 1, 8'h5C};
    vt[3] = '{0, 4'h2, 8'h00, 1, 1, 0, 8'h1A};
    vt[4] = '{1, 4'h6, 8'h77, 0, 0, 0, 8'h00};
    vt[5] = '{0, 4'h6, 8'h00, 1, 0, 0, 8'h5C};
    vt[6] = '{1, 4'hF, 8'hC3, 1, 2, 0, 8'h00};
    vt[7] = '{0, 4'hF, 8'h00, 1, 0, 0, 8'hC3};

    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

    repeat (3) @(negedge mclk);
    reset_n = 1;
    @(negedge mclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cs", reg_cs, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_be", reg_be, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);

    // ack while idle must be ignored
    spur = 1;
    @(negedge mclk);
    spur = 0;
    @(negedge mclk);
    chk("idle_ack_ready", cmd_ready, 1);
    chk("idle_ack_valid", rsp_valid, 0);
    chk("idle_ack_cs", reg_cs, 0);

    mon_en = 1;
    for (int i = 0; i < 8; i++) begin
      do_txn(vt[i].wr, vt[i].a, vt[i].d, vt[i].be,
             vt[i].hold, vt[i].sp, rd, er, lat, acks);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), er, 0);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_acks", i), acks, 1);
      if (vt[i].wr && vt[i].be) ref_mem[vt[i].a] = vt[i].d;
    end

    for (int i = 0; i < 40; i++) begin
      logic w, b;
      logic [3:0] a;
      logic [7:0] d, e;
      w = 1'($urandom % 2);
      a = 4'($urandom % 16);
      d = 8'($urandom);
      b = ($urandom % 4) != 0;
      e = w ? 8'h00 : ref_mem[a];
      do_txn(w, a, d, b, int'($urandom % 3), 0, rd, er, lat, acks);
      chk($sformatf("rnd%0d_rdata", i), rd, e);
      chk($sformatf("rnd%0d_err", i), er, 0);
      chk($sformatf("rnd%0d_lat", i), lat, 3);
      chk($sformatf("rnd%0d_acks", i), acks, 1);
      if (w && b) ref_mem[a] = d;
    end

    // back-to-back writes with cmd_valid held high
    mon_en = 0;
    p0 = pulses;
    a0 = ack_cnt;
    @(negedge mclk);
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 4'h5;
    cmd_wdata = 8'h41; cmd_be = 1; rsp_ready = 1;
    @(negedge mclk);
    cmd_wdata = 8'h42;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge mclk); n++;
    end
    chk("b2b_second_accept", cmd_ready, 1);
    @(negedge mclk);
    cmd_valid = 0;
    repeat (5) @(negedge mclk);
    rsp_ready = 0;
    ref_mem[5] = 8'h42;
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_acks", ack_cnt - a0, 2);
    chk("b2b_gap", gap_last >= 1, 1);
    chk("b2b_mem", mem[5], ref_mem[5]);
    mon_en = 1;
    do_txn(0, 4'h5, 8'h00, 1, 0, 0, rd, er, lat, acks);
    chk("b2b_readback", rd, 8'h42);

`ifdef REG_MSTR_TIMEOUT_EN
    // silent responder: abort after the counter reaches TO
    mon_en = 0;
    noack = 1;
    do_txn(0, 4'h1, 8'h00, 1, 3, 1, rd, er, lat, acks);
    noack = 0;
    chk("to_rdata", rd, 8'hFF);
    chk("to_err", er, 1);
    chk("to_lat", lat, TO + 2);
    chk("to_acks", acks, 0);
    chk("to_cs_low", reg_cs, 0);
    mon_en = 1;
    do_txn(0, 4'h6, 8'h00, 1, 0, 0, rd, er, lat, acks);
    chk("to_after_rdata", rd, ref_mem[6]);
    chk("to_after_err", er, 0);
`endif

    // reset in the middle of REQ
    mon_en = 0;
    noack = 1;
    @(negedge mclk);
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 4'h3;
    @(negedge mclk);
    cmd_valid = 0;
    chk("mid_cs_up", reg_cs, 1);
    @(negedge mclk);
    #2 reset_n = 0;
    #1 chk("mid_cs_async", reg_cs, 0);
    noack = 0;
    @(negedge mclk);
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      chk("mid_no_rsp", rsp_valid, 0);
    end
    chk("mid_idle", cmd_ready, 1);
    chk("mid_cs", reg_cs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
